// File: rtl/bus_pkg.sv
// Shared types and widths for the 8088-style multiplexed byte bus.
package bus_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 8;

  // Bus operation encoding, matches the processor-side interface enum.
  typedef enum logic {
    leer     = 1'b0,
    escribir = 1'b1
  } operacion;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    WAIT = 3'd2,
    DATA = 3'd3,
    TURN = 3'd4
  } resp_state_t;

endpackage

// File: rtl/bus_mem_array.sv
// Single-port synchronous byte array. Read data is registered every cycle
// from the presented address; a write lands on the same edge. No reset on
// the storage itself.
module bus_mem_array #(
  parameter int DEPTH_LOG2 = 8,
  parameter int DATA_W     = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  // Registered read of the current address, optional write of the same word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/bus_mem_responder.sv
// Memory-side responder for the multiplexed byte bus: accepts a bus cycle,
// inserts WAIT_STATES wait cycles, then returns or stores one byte and
// strobes READY (with ERR when the address misses the decode window).
//
// state | meaning
// IDLE  | waiting for EN; address, operation and window hit latched on accept
// ADDR  | address phase; wait counter loaded
// WAIT  | wait states, counter counts down to terminal value 1
// DATA  | single data cycle; READY high, read data driven or write committed
// TURN  | bus turnaround; responder off the bus, EN ignored
module bus_mem_responder import bus_pkg::*; #(
  parameter logic [ADDR_W-1:0] BASE        = 20'h00000,
  parameter int                DEPTH_LOG2  = 8,
  parameter int                WAIT_STATES = 1,
  parameter logic [DATA_W-1:0] FILL_BYTE   = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              EN,
  input  logic              RD_WR,
  input  logic [ADDR_W-1:0] Direction,
  input  logic [DATA_W-1:0] Bus_in,
  output logic [DATA_W-1:0] Bus_out,
  output logic              Bus_oe,
  output logic              READY,
  output logic              ERR,
  output logic              Busy
);

  localparam logic [3:0] WS = WAIT_STATES[3:0];

  resp_state_t           state_q, state_d;
  logic [DEPTH_LOG2-1:0] off_q, off_d;
  operacion              op_q, op_d;
  logic                  in_win_q, in_win_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  ready_q, err_q, oe_q, busy_q;

  logic [ADDR_W-1:0]     diff;
  logic                  we;
  logic [DATA_W-1:0]     rdata;

  // Offset from BASE; anything below BASE wraps to a large value and misses.
  assign diff = Direction - BASE;

  // Next-state, latch and wait-counter logic.
  always_comb begin
    state_d  = state_q;
    off_d    = off_q;
    op_d     = op_q;
    in_win_d = in_win_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (EN) begin
          off_d    = diff[DEPTH_LOG2-1:0];
          op_d     = operacion'(RD_WR);
          in_win_d = ((diff >> DEPTH_LOG2) == '0);
          state_d  = ADDR;
        end
      end
      ADDR: begin
        cnt_d   = WS;
        state_d = (WS != 4'd0) ? WAIT : DATA;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = DATA;
        end
      end
      DATA:    state_d = TURN;
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched request and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      off_q    <= '0;
      op_q     <= leer;
      in_win_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      off_q    <= off_d;
      op_q     <= op_d;
      in_win_q <= in_win_d;
      cnt_q    <= cnt_d;
    end
  end

  // Output strobes registered from the next state so they line up with DATA.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ready_q <= (state_d == DATA);
      err_q   <= (state_d == DATA) && !in_win_d;
      oe_q    <= (state_d == DATA) && (op_d == leer);
      busy_q  <= (state_d != IDLE);
    end
  end

  // Writes commit on the edge that closes DATA, and only inside the window.
  assign we = (state_q == DATA) && (op_q == escribir) && in_win_q;

  bus_mem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .addr  (off_q),
    .wdata (Bus_in),
    .rdata (rdata)
  );

  // Read byte is only presented while the responder owns the bus.
  assign Bus_out = oe_q ? (in_win_q ? rdata : FILL_BYTE) : '0;
  assign Bus_oe  = oe_q;
  assign READY   = ready_q;
  assign ERR     = err_q;
  assign Busy    = busy_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Bench for bus_mem_responder: three instances (1, 0 and 15 wait states),
// a byte-array reference model, a vector table, random traffic and
// hand-written reset / back-to-back / late-change sequences.
module tb_bus_mem_responder;
  import bus_pkg::*;

  typedef struct {
    logic        op;
    logic [19:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rd;
    logic        exp_err;
    logic        exp_oe;
    int          exp_lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en   [3];
  logic        rdwr [3];
  logic [19:0] dir  [3];
  logic [7:0]  bin  [3];
  logic [7:0]  bout [3];
  logic        boe  [3];
  logic        rdy  [3];
  logic        err  [3];
  logic        busy [3];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic        mon_en  = 1'b0;
  logic [7:0]  ref_mem [256];
  vec_t        vt [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bus_mem_responder #(.BASE(20'h00000), .DEPTH_LOG2(8), .WAIT_STATES(1), .FILL_BYTE(8'hFF)) dut (
    .clk(clk), .reset(rst_n), .EN(en[0]), .RD_WR(rdwr[0]), .Direction(dir[0]), .Bus_in(bin[0]),
    .Bus_out(bout[0]), .Bus_oe(boe[0]), .READY(rdy[0]), .ERR(err[0]), .Busy(busy[0]));

  bus_mem_responder #(.BASE(20'h00100), .DEPTH_LOG2(8), .WAIT_STATES(0), .FILL_BYTE(8'hFF)) dut_ws0 (
    .clk(clk), .reset(rst_n), .EN(en[1]), .RD_WR(rdwr[1]), .Direction(dir[1]), .Bus_in(bin[1]),
    .Bus_out(bout[1]), .Bus_oe(boe[1]), .READY(rdy[1]), .ERR(err[1]), .Busy(busy[1]));

  bus_mem_responder #(.BASE(20'h00000), .DEPTH_LOG2(8), .WAIT_STATES(15), .FILL_BYTE(8'hFF)) dut_ws15 (
    .clk(clk), .reset(rst_n), .EN(en[2]), .RD_WR(rdwr[2]), .Direction(dir[2]), .Bus_in(bin[2]),
    .Bus_out(bout[2]), .Bus_oe(boe[2]), .READY(rdy[2]), .ERR(err[2]), .Busy(busy[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus_oe and ERR may only be seen together with READY.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 3; d++) begin
        check("oe_without_ready", 32'(boe[d] & ~rdy[d]), 32'd0);
        check("err_without_ready", 32'(err[d] & ~rdy[d]), 32'd0);
      end
    end
  end

  // One complete bus cycle on instance d; returns what was seen in DATA.
  task automatic txn(input int d, input logic op, input logic [19:0] a, input logic [7:0] wd,
                     output logic [7:0] rd, output int lat, output logic er, output logic oe);
    @(negedge clk);
    en[d] = 1'b1; rdwr[d] = op; dir[d] = a; bin[d] = wd;
    @(posedge clk); #1;
    en[d] = 1'b0;
    lat = 1;
    while (rdy[d] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("ready_seen", 32'(rdy[d]), 32'd1);
    rd = bout[d]; er = err[d]; oe = boe[d];
    @(posedge clk); #1;
    check("turn_ready_low", 32'(rdy[d]), 32'd0);
    check("turn_oe_low", 32'(boe[d]), 32'd0);
    check("turn_busy", 32'(busy[d]), 32'd1);
    @(posedge clk); #1;
    check("idle_busy_low", 32'(busy[d]), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  rd, v8;
    logic [19:0] a;
    logic        er, oe, op, inw;
    int          lat, t, last;

    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      en[d] = 1'b0; rdwr[d] = 1'b0; dir[d] = '0; bin[d] = '0;
    end
    #2;
    for (int d = 0; d < 3; d++) begin
      check("reset_ready", 32'(rdy[d]), 32'd0);
      check("reset_oe", 32'(boe[d]), 32'd0);
      check("reset_busout", 32'(bout[d]), 32'd0);
      check("reset_err", 32'(err[d]), 32'd0);
      check("reset_busy", 32'(busy[d]), 32'd0);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Fill the whole window so every later read has a known value.
    for (int i = 0; i < 256; i++) begin
      if (i == 8'h45)      v8 = 8'h96;
      else if (i == 8'h20) v8 = 8'h11;
      else                 v8 = 8'($urandom);
      ref_mem[i] = v8;
      txn(0, 1'b1, 20'(i), v8, rd, lat, er, oe);
    end

    vt.push_back('{1'b1, 20'h00010, 8'hA5, 8'h00,         1'b0, 1'b0, 3});
    vt.push_back('{1'b0, 20'h00010, 8'h00, 8'hA5,         1'b0, 1'b1, 3});
    vt.push_back('{1'b0, 20'h12345, 8'h00, 8'hFF,         1'b1, 1'b1, 3});
    vt.push_back('{1'b1, 20'h12345, 8'h3C, 8'h00,         1'b1, 1'b0, 3});
    vt.push_back('{1'b0, 20'h00045, 8'h00, ref_mem[8'h45], 1'b0, 1'b1, 3});
    vt.push_back('{1'b0, 20'h000FF, 8'h00, ref_mem[8'hFF], 1'b0, 1'b1, 3});
    vt.push_back('{1'b0, 20'h00100, 8'h00, 8'hFF,         1'b1, 1'b1, 3});
    vt.push_back('{1'b0, 20'hFFFFF, 8'h00, 8'hFF,         1'b1, 1'b1, 3});
    vt.push_back('{1'b1, 20'h000FF, 8'h5A, 8'h00,         1'b0, 1'b0, 3});
    vt.push_back('{1'b0, 20'h000FF, 8'h00, 8'h5A,         1'b0, 1'b1, 3});
    vt.push_back('{1'b0, 20'h00000, 8'h00, ref_mem[8'h00], 1'b0, 1'b1, 3});

    foreach (vt[i]) begin
      txn(0, vt[i].op, vt[i].addr, vt[i].wdata, rd, lat, er, oe);
      check("vec_latency", 32'(lat), 32'(vt[i].exp_lat));
      check("vec_err", 32'(er), 32'(vt[i].exp_err));
      check("vec_oe", 32'(oe), 32'(vt[i].exp_oe));
      if (vt[i].op == 1'b0) check("vec_rdata", 32'(rd), 32'(vt[i].exp_rd));
      if (vt[i].op == 1'b1 && vt[i].addr < 20'h100) ref_mem[vt[i].addr[7:0]] = vt[i].wdata;
    end

    // EN held high across three reads: READY every 5 clocks, bus released in TURN.
    @(negedge clk);
    en[0] = 1'b1; rdwr[0] = 1'b0; dir[0] = 20'h00000;
    last = 0;
    for (int k = 0; k < 3; k++) begin
      t = 0;
      while (rdy[0] !== 1'b1 && t < 20) begin
        @(posedge clk); #1;
        t++;
      end
      check("b2b_ready", 32'(rdy[0]), 32'd1);
      check("b2b_rdata", 32'(bout[0]), 32'(ref_mem[k]));
      if (k > 0) check("b2b_spacing", 32'(cyc - last), 32'd5);
      last = cyc;
      dir[0] = 20'(k + 1);
      if (k == 2) en[0] = 1'b0;
      @(posedge clk); #1;
      check("b2b_turn_oe", 32'(boe[0]), 32'd0);
      check("b2b_turn_ready", 32'(rdy[0]), 32'd0);
    end
    @(posedge clk); #1;

    // Reset during WAIT of a write: nothing commits, outputs drop immediately.
    @(negedge clk);
    en[0] = 1'b1; rdwr[0] = 1'b1; dir[0] = 20'h00020; bin[0] = 8'h77;
    @(posedge clk); #1;
    en[0] = 1'b0;
    @(posedge clk); #1;
    check("rst_pre_busy", 32'(busy[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ready", 32'(rdy[0]), 32'd0);
    check("rst_mid_oe", 32'(boe[0]), 32'd0);
    check("rst_mid_err", 32'(err[0]), 32'd0);
    check("rst_mid_busy", 32'(busy[0]), 32'd0);
    check("rst_mid_busout", 32'(bout[0]), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_idle_busy", 32'(busy[0]), 32'd0);
    txn(0, 1'b0, 20'h00020, 8'h00, rd, lat, er, oe);
    check("rst_no_commit", 32'(rd), 32'(ref_mem[8'h20]));

    // Direction / RD_WR changed after acceptance must be ignored.
    @(negedge clk);
    en[0] = 1'b1; rdwr[0] = 1'b0; dir[0] = 20'h00030; bin[0] = 8'hEE;
    @(posedge clk); #1;
    en[0] = 1'b0; dir[0] = 20'h00031; rdwr[0] = 1'b1;
    lat = 1;
    while (rdy[0] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("late_ready", 32'(rdy[0]), 32'd1);
    check("late_latency", 32'(lat), 32'd3);
    check("late_rdata", 32'(bout[0]), 32'(ref_mem[8'h30]));
    check("late_oe", 32'(boe[0]), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    txn(0, 1'b0, 20'h00031, 8'h00, rd, lat, er, oe);
    check("late_no_write", 32'(rd), 32'(ref_mem[8'h31]));

    // Zero wait states, window starting at 0x100.
    txn(1, 1'b1, 20'h00100, 8'h5A, rd, lat, er, oe);
    check("ws0_wr_latency", 32'(lat), 32'd2);
    check("ws0_wr_err", 32'(er), 32'd0);
    check("ws0_wr_oe", 32'(oe), 32'd0);
    txn(1, 1'b0, 20'h00100, 8'h00, rd, lat, er, oe);
    check("ws0_rd_latency", 32'(lat), 32'd2);
    check("ws0_rd_data", 32'(rd), 32'h5A);
    check("ws0_rd_oe", 32'(oe), 32'd1);
    txn(1, 1'b1, 20'h001FF, 8'hC3, rd, lat, er, oe);
    check("ws0_top_err", 32'(er), 32'd0);
    txn(1, 1'b0, 20'h001FF, 8'h00, rd, lat, er, oe);
    check("ws0_top_data", 32'(rd), 32'hC3);
    txn(1, 1'b0, 20'h000FF, 8'h00, rd, lat, er, oe);
    check("ws0_below_err", 32'(er), 32'd1);
    check("ws0_below_data", 32'(rd), 32'hFF);
    txn(1, 1'b0, 20'h00200, 8'h00, rd, lat, er, oe);
    check("ws0_above_err", 32'(er), 32'd1);
    check("ws0_above_data", 32'(rd), 32'hFF);

    // Maximum wait states.
    txn(2, 1'b0, 20'h00005, 8'h00, rd, lat, er, oe);
    check("ws15_latency", 32'(lat), 32'd17);
    check("ws15_err", 32'(er), 32'd0);
    txn(2, 1'b0, 20'h00100, 8'h00, rd, lat, er, oe);
    check("ws15_oow_latency", 32'(lat), 32'd17);
    check("ws15_oow_err", 32'(er), 32'd1);
    check("ws15_oow_data", 32'(rd), 32'hFF);

    // Random traffic against the byte-array model.
    for (int i = 0; i < 60; i++) begin
      op = 1'($urandom);
      a  = ($urandom_range(0, 3) != 0) ? 20'($urandom_range(0, 255)) : 20'($urandom);
      v8 = 8'($urandom);
      inw = (a < 20'h00100);
      txn(0, op, a, v8, rd, lat, er, oe);
      check("rnd_latency", 32'(lat), 32'd3);
      check("rnd_err", 32'(er), 32'(!inw));
      check("rnd_oe", 32'(oe), 32'(!op));
      if (!op) check("rnd_rdata", 32'(rd), inw ? 32'(ref_mem[a[7:0]]) : 32'hFF);
      if (op && inw) ref_mem[a[7:0]] = v8;
    end

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_mem_responder.md
Name: bus_mem_responder

Overview:
Memory-side responder for the 8088-style multiplexed byte bus. It is the other end of the bus that the processor's bus interface unit drives. It accepts a bus cycle request (EN, RD_WR, 20-bit Direction) and inserts a programmable number of wait states. It then returns a byte on reads or stores a byte on writes, and signals completion with READY. It replaces the bench-driven Data/RD_WR pins in system-level simulation.

Parameters:
BASE, 20'h00000, first physical address decoded by this responder
DEPTH_LOG2, 8, log2 of byte array depth; window = [BASE, BASE + 2**DEPTH_LOG2 - 1]
WAIT_STATES, 1, wait cycles inserted between address and data phase (0..15)
FILL_BYTE, 8'hFF, byte returned on reads outside the window

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted at 0)
EN  input  1  bus cycle request from BIU, sampled in IDLE only
RD_WR  input  1  0 = leer (read), 1 = escribir (write), latched with address
Direction  input  20  physical address, latched with EN
Bus_in  input  8  write data from BIU, sampled in DATA state
Bus_out  output  8  read data, valid only while Bus_oe = 1
Bus_oe  output  1  responder drives the shared Bus (top-level tristate: Bus = Bus_oe ? Bus_out : 'z)
READY  output  1  one-cycle completion strobe
ERR  output  1  one-cycle strobe coincident with READY when the address is outside the window
Busy  output  1  high in every state except IDLE

Behaviour:
- Reset (reset = 0, async): state IDLE; Bus_out = 0, Bus_oe = 0, READY = 0, ERR = 0, Busy = 0; wait counter = 0; latched addr/op = 0. Array contents are not cleared.
- FSM states: IDLE, ADDR, WAIT, DATA, TURN. One state per clock.
- IDLE: on rising edge with EN = 1, latch Direction, RD_WR and in_window = (Direction - BASE) < 2**DEPTH_LOG2 (20-bit unsigned, no wrap). Then go to ADDR. Otherwise stay.
- ADDR: load wait counter with WAIT_STATES. Go to WAIT if WAIT_STATES > 0, else go to DATA.
- WAIT: decrement counter. Go to DATA when the counter reaches 1 on this edge, so exactly WAIT_STATES cycles are spent in WAIT.
- DATA (exactly one cycle):
  - READY = 1.
  - Read: Bus_oe = 1; Bus_out = mem[addr - BASE] if in window, else FILL_BYTE.
  - Write: at the closing edge, mem[addr - BASE] <= Bus_in if in window. Out-of-window writes are discarded.
  - ERR = !in_window.
  - Go to TURN.
- TURN: Bus_oe = 0, READY = 0 (bus turnaround). Go to IDLE unconditionally. EN is not sampled in TURN.
- Latency: EN seen at edge k. DATA occupies the cycle after edge k+1+WAIT_STATES. Back-to-back cycles with EN held high: one cycle every 4 + WAIT_STATES clocks.
- Outputs are registered, decoded from the state register; no combinational path from inputs to outputs.
- EN, RD_WR and Direction changes after acceptance are ignored; an accepted cycle always completes.
- Bus_oe is never 1 outside DATA; it is never 1 on a write cycle.
- Reset asserted mid-cycle: immediate return to IDLE with outputs zeroed. An in-flight write does not commit unless its DATA closing edge has already occurred.
- Memory is a single-port synchronous array: read data registered on entry to DATA, write on DATA exit.

Decomposition:
- Package bus_pkg:
  - typedef operacion {leer = 1'b0, escribir = 1'b1}, matching the interface enum.
  - typedef resp_state_t {IDLE, ADDR, WAIT, DATA, TURN}.
  - Localparams ADDR_W = 20, DATA_W = 8.
- Sub-module bus_mem_array: single-port sync RAM, parameters DEPTH_LOG2 and DATA_W; ports clk, we, addr, wdata, rdata. No reset on storage.
- Top module: FSM, window decode, wait counter, output registers.

Test Plan:
- WAIT_STATES = 1: write 8'hA5 to 20'h00010, then read 20'h00010. Write READY is 3 clocks after EN is accepted, Bus_oe = 0. Read returns Bus_out = 8'hA5 with Bus_oe = 1 for exactly one cycle, ERR = 0.
- Read 20'h12345, outside the BASE = 0 window with DEPTH_LOG2 = 8 -> Bus_out = 8'hFF, READY = ERR = 1 for one cycle. Then write 8'h3C to 20'h12345 and read 20'h00045 -> the out-of-window write left 20'h00045 unchanged (no aliasing).
- EN held high for 3 consecutive reads of 20'h00000..20'h00002 -> READY pulses spaced exactly 5 clocks apart. Bus_oe low in every TURN cycle.
- Assert reset = 0 during WAIT of a write of 8'h77 to 20'h00020 -> outputs 0 within the same cycle, FSM in IDLE, later read of 20'h00020 does not return 8'h77.
- WAIT_STATES = 0 build: read completes with READY 2 clocks after acceptance. WAIT_STATES = 15: READY 17 clocks after acceptance.
- Change Direction and RD_WR during WAIT -> the cycle completes using the originally latched address and operation.
